// File: rtl/output_interface.sv
// ============================================================================
// output_interface: serialises a 128-bit ciphertext block into 16 host bytes
// with valid/ack handshake, done pulse and sticky overrun flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_interface #(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit HOLD_LEVEL = 1'b1
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [127:0] cipher_in,
    input  logic         transformer_done,
    output logic [7:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ack,
    output logic         ready,
    output logic         out_done,
    output logic         overrun,
    input  logic         clr_ovr
);

    typedef enum logic [1:0] {
        S_ID = 2'd0,
        S_TX = 2'd1,
        S_DN = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   shreg;
    logic [3:0]     cnt;
    logic           done_prev;
    logic           capture;
    logic           accept;

    // Level mode only reacts to the low-to-high transition of the engine flag.
    assign capture = HOLD_LEVEL ? (transformer_done & ~done_prev) : transformer_done;
    assign accept  = (state == S_TX) & dout_ack;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state <= S_ID;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ID: if (capture) state_nxt = S_TX;
            S_TX: if (accept && (cnt == 4'hF)) state_nxt = S_DN;
            S_DN: state_nxt = S_ID;
            default: state_nxt = S_ID;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            shreg     <= 128'h0;
            cnt       <= 4'h0;
            done_prev <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_prev <= transformer_done;
            if ((state == S_ID) && capture) begin
                shreg <= cipher_in;
                cnt   <= 4'h0;
            end else if (accept) begin
                if (MSB_FIRST) begin
                    shreg <= {shreg[119:0], 8'h00};
                end else begin
                    shreg <= {8'h00, shreg[127:8]};
                end
                cnt <= cnt + 4'h1;
            end
            // A new overrun event wins over a simultaneous clear.
            if (capture && (state != S_ID)) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign dout       = (state == S_TX) ? (MSB_FIRST ? shreg[127:120] : shreg[7:0]) : 8'h00;
    assign dout_valid = (state == S_TX);
    assign ready      = (state == S_ID);
    assign out_done   = (state == S_DN);

endmodule

`default_nettype wire

// File: tb/tb_output_interface.sv
// ============================================================================
// tb_output_interface: scoreboard bench for MSB-first and LSB-first instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_output_interface;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [127:0] cipher_in = 128'h0;
    logic         transformer_done = 1'b0;
    logic         dout_ack = 1'b0;
    logic         clr_ovr = 1'b0;

    logic [7:0]   dout_a, dout_b;
    logic         valid_a, valid_b, ready_a, ready_b;
    logic         done_a, done_b, ovr_a, ovr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_interface #(.MSB_FIRST(1'b1), .HOLD_LEVEL(1'b1)) u_msb (
        .clk(clk), .rst_(rst_), .cipher_in(cipher_in), .transformer_done(transformer_done),
        .dout(dout_a), .dout_valid(valid_a), .dout_ack(dout_ack), .ready(ready_a),
        .out_done(done_a), .overrun(ovr_a), .clr_ovr(clr_ovr)
    );

    output_interface #(.MSB_FIRST(1'b0), .HOLD_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst_(rst_), .cipher_in(cipher_in), .transformer_done(transformer_done),
        .dout(dout_b), .dout_valid(valid_b), .dout_ack(dout_ack), .ready(ready_b),
        .out_done(done_b), .overrun(ovr_b), .clr_ovr(clr_ovr)
    );

    // Expected byte streams, filled when the model sees a capture.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    // Transaction-level model: idle / sending N bytes / one-cycle done.
    int  phase    = 0;
    int  left     = 0;
    bit  exp_ovr  = 1'b0;
    bit  prev_d   = 1'b0;
    bit  known    = 1'b0;
    int  captures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit d, input bit ack, input bit clr,
                                input logic [127:0] c);
        bit cap;
        bit set;
        if (r) begin
            phase = 0; left = 0; exp_ovr = 1'b0; prev_d = 1'b0; known = 1'b1;
            qa.delete(); qb.delete();
            return;
        end
        cap = d && !prev_d;
        prev_d = d;
        set = 1'b0;
        if (phase == 0) begin
            if (cap) begin
                for (int i = 0; i < 16; i++) begin
                    qa.push_back(c[127 - 8*i -: 8]);
                    qb.push_back(c[8*i +: 8]);
                end
                left = 16; phase = 1; captures++;
            end
        end else if (phase == 1) begin
            if (cap) set = 1'b1;
            if (ack) begin
                left--;
                if (left == 0) phase = 2;
            end
        end else begin
            if (cap) set = 1'b1;
            phase = 0;
        end
        if (set) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
    endtask

    // One clock: check the state produced by the last edge, then drive the next inputs.
    task automatic step(input bit r, input bit d, input bit ack, input bit clr,
                        input logic [127:0] c);
        @(posedge clk);
        #1;
        if (known) begin
            chk("ready_a",  ready_a, (phase == 0));
            chk("valid_a",  valid_a, (phase == 1));
            chk("outdone_a", done_a, (phase == 2));
            chk("overrun_a", ovr_a,  exp_ovr);
            chk("ready_b",  ready_b, (phase == 0));
            chk("valid_b",  valid_b, (phase == 1));
            chk("outdone_b", done_b, (phase == 2));
            chk("overrun_b", ovr_b,  exp_ovr);
            if (phase != 1) begin
                chk("dout_idle_a", dout_a, 8'h00);
                chk("dout_idle_b", dout_b, 8'h00);
            end
        end
        rst_ = r; transformer_done = d; dout_ack = ack; clr_ovr = clr; cipher_in = c;
        model_update(r, d, ack, clr, c);
    endtask

    task automatic wait_idle(input bit ack);
        int n = 0;
        while (phase != 0 && n < 80) begin
            step(1'b0, 1'b0, ack, 1'b0, 128'h0);
            n++;
        end
        if (phase != 0) begin
            total++; bad++;
            $display("FAIL wait_idle: timeout phase=%0d expected 0", phase);
        end
    endtask

    // Scoreboard monitor: compares every presented byte, pops on acceptance.
    int acc_a = 0;
    int acc_b = 0;
    always @(negedge clk) begin
        if (rst_ === 1'b1) begin
            acc_a = 0; acc_b = 0;
        end else if (known) begin
            if (done_a) begin chk("count_a", acc_a, 16); acc_a = 0; end
            if (done_b) begin chk("count_b", acc_b, 16); acc_b = 0; end
            if (valid_a) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL byte_a: got %0h expected none", dout_a);
                end else begin
                    chk("byte_a", dout_a, qa[0]);
                    if (dout_ack) begin void'(qa.pop_front()); acc_a++; end
                end
            end
            if (valid_b) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL byte_b: got %0h expected none", dout_b);
                end else begin
                    chk("byte_b", dout_b, qb[0]);
                    if (dout_ack) begin void'(qb.pop_front()); acc_b++; end
                end
            end
        end
    end

    localparam logic [127:0] BLK = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        int cap0;
        logic [127:0] rc;
        bit rd;
        step(1'b1, 1'b0, 1'b0, 1'b0, 128'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 128'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);

        // Back-to-back MSB/LSB transfer.
        step(1'b0, 1'b1, 1'b1, 1'b0, BLK);
        wait_idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);

        // Stalled host: ack every third cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, BLK);
        for (int k = 0; k < 80 && phase != 0; k++)
            step(1'b0, 1'b0, (k % 3 == 2), 1'b0, 128'h0);
        wait_idle(1'b1);

        // Overrun after five accepted bytes, then clear while idle.
        step(1'b0, 1'b1, 1'b1, 1'b0, BLK);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 128'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, {128{1'b1}});
        wait_idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
        chk("overrun_set", ovr_a, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 128'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
        chk("overrun_clr", ovr_a, 1'b0);

        // Reset after eight bytes.
        step(1'b0, 1'b1, 1'b1, 1'b0, BLK);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 128'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 128'h0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 128'h0);

        // Done held high for 40 cycles: a single capture.
        cap0 = captures;
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b1, 1'b0, BLK);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
        chk("single_capture", captures - cap0, 1);

        // Randomised traffic.
        rd = 1'b0;
        for (int k = 0; k < 600; k++) begin
            rc = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rd = ~rd;
            step(($urandom_range(0, 149) == 0), rd, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0), rc);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 128'h0);
        wait_idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
